// File: rtl/turfio_word_align.sv
// TURFIO word aligner: packs ISERDES nibbles into 8-bit words and slips the bit offset
// until the training byte is seen LOCK_COUNT times in a row, then holds lock.
module turfio_word_align #(
   parameter logic [7:0]  TRAIN_PATTERN = 8'hA9,
   parameter int unsigned LOCK_COUNT    = 8
) (
   input  logic        if_clk_i,
   input  logic        rst_n_i,
   input  logic [3:0]  data_i,
   input  logic        start_i,
   input  logic        check_i,
   output logic [7:0]  word_o,
   output logic        word_valid_o,
   output logic [2:0]  offset_o,
   output logic        locked_o,
   output logic        fail_o,
   output logic [15:0] err_cnt_o
);

   localparam int unsigned HIST_W   = 16;
   localparam int unsigned OFF_W    = 3;
   localparam int unsigned ATT_W    = 4;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned ERR_W    = 16;
   localparam logic [CNT_W-1:0] LOCK_CNT  = CNT_W'(LOCK_COUNT);
   localparam logic [ATT_W-1:0] LAST_ATT  = ATT_W'(7);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEARCH,
      S_VERIFY,
      S_LOCKED,
      S_FAIL
   } state_e;

   state_e              state_q, state_d;
   logic [HIST_W-1:0]   hist_q, hist_d;
   logic                phase_q, phase_d;
   logic [OFF_W-1:0]    offset_q, offset_d;
   logic [ATT_W-1:0]    attempts_q, attempts_d;
   logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
   logic                settle_q, settle_d;
   logic [7:0]          word_q, word_d;
   logic                word_valid_q, word_valid_d;
   logic                locked_q, locked_d;
   logic                fail_q, fail_d;
   logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

   logic                strobe;
   logic                cmp_slot;
   logic                match;
   logic                slip;
   logic [7:0]          cand;

   assign hist_d   = {hist_q[HIST_W-5:0], data_i};
   assign phase_d  = ~phase_q;
   assign strobe   = phase_q;
   // The strobe right after an offset change sees a word straddling two alignments.
   assign cmp_slot = strobe & ~settle_q;
   assign cand     = 8'(hist_d >> offset_q);
   assign match    = (cand == TRAIN_PATTERN);

   // Next-state and output logic for the search / verify / lock sequence.
   always_comb begin
      state_d      = state_q;
      offset_d     = offset_q;
      attempts_d   = attempts_q;
      match_cnt_d  = match_cnt_q;
      err_cnt_d    = err_cnt_q;
      settle_d     = settle_q & ~strobe;
      word_d       = word_q;
      word_valid_d = 1'b0;
      slip         = 1'b0;

      if (cmp_slot && state_q != S_IDLE && state_q != S_FAIL) begin
         word_valid_d = 1'b1;
         word_d       = cand;
      end

      if (start_i) begin
         state_d     = S_SEARCH;
         attempts_d  = '0;
         match_cnt_d = '0;
         err_cnt_d   = '0;
      end else if (cmp_slot) begin
         case (state_q)
            S_SEARCH: begin
               if (match) begin
                  match_cnt_d = CNT_W'(1);
                  state_d     = (LOCK_CNT == CNT_W'(1)) ? S_LOCKED : S_VERIFY;
               end else begin
                  slip = 1'b1;
               end
            end
            S_VERIFY: begin
               if (match) begin
                  match_cnt_d = match_cnt_q + CNT_W'(1);
                  if (match_cnt_q + CNT_W'(1) == LOCK_CNT) begin
                     state_d = S_LOCKED;
                  end
               end else begin
                  slip = 1'b1;
               end
            end
            S_LOCKED: begin
               if (check_i && !match && err_cnt_q != ERR_MAX) begin
                  err_cnt_d = err_cnt_q + ERR_W'(1);
               end
            end
            default: ;
         endcase
      end

      // Eighth slip since start means every offset has been tried.
      if (slip) begin
         offset_d    = offset_q + OFF_W'(1);
         attempts_d  = attempts_q + ATT_W'(1);
         match_cnt_d = '0;
         settle_d    = 1'b1;
         state_d     = (attempts_q == LAST_ATT) ? S_FAIL : S_SEARCH;
      end

      locked_d = (state_d == S_LOCKED);
      fail_d   = (state_d == S_FAIL);
   end

   always_ff @(posedge if_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         hist_q       <= '0;
         phase_q      <= 1'b0;
         offset_q     <= '0;
         attempts_q   <= '0;
         match_cnt_q  <= '0;
         settle_q     <= 1'b0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         hist_q       <= hist_d;
         phase_q      <= phase_d;
         offset_q     <= offset_d;
         attempts_q   <= attempts_d;
         match_cnt_q  <= match_cnt_d;
         settle_q     <= settle_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         locked_q     <= locked_d;
         fail_q       <= fail_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign word_o       = word_q;
   assign word_valid_o = word_valid_q;
   assign offset_o     = offset_q;
   assign locked_o     = locked_q;
   assign fail_o       = fail_q;
   assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_turfio_word_align.sv
// Bench for turfio_word_align: bit-stream reference model driven by directed and random streams.
module tb_turfio_word_align;

   localparam logic [7:0] PAT   = 8'hA9;
   localparam int         LOCKN = 8;
   localparam int MD_IDLE = 0, MD_SEARCH = 1, MD_VERIFY = 2, MD_LOCKED = 3, MD_FAIL = 4;

   logic        clk;
   logic        rst_n;
   logic [3:0]  data_i;
   logic        start_i;
   logic        check_i;
   logic [7:0]  word_o;
   logic        word_valid_o;
   logic [2:0]  offset_o;
   logic        locked_o;
   logic        fail_o;
   logic [15:0] err_cnt_o;

   turfio_word_align dut (
      .if_clk_i     (clk),
      .rst_n_i      (rst_n),
      .data_i       (data_i),
      .start_i      (start_i),
      .check_i      (check_i),
      .word_o       (word_o),
      .word_valid_o (word_valid_o),
      .offset_o     (offset_o),
      .locked_o     (locked_o),
      .fail_o       (fail_o),
      .err_cnt_o    (err_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model: received bit history (earliest first) plus alignment bookkeeping
   bit         m_bits[$];
   int         m_cyc, m_mode, m_off, m_tries, m_hits, m_errs;
   bit         m_skip, m_valid;
   logic [7:0] m_word;

   // serial source
   int         src_idx, src_shift, src_mode;
   logic [7:0] pat_reg;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic mdl_reset();
      m_bits.delete();
      for (int i = 0; i < 16; i++) m_bits.push_back(1'b0);
      m_cyc = 0; m_mode = MD_IDLE; m_off = 0; m_tries = 0; m_hits = 0; m_errs = 0;
      m_skip = 1'b0; m_valid = 1'b0; m_word = 8'h00;
   endtask

   task automatic mdl_step(input logic [3:0] d, input bit st, input bit ck);
      logic [7:0] cand;
      bit         strobe;
      bit         act;
      int         n;
      for (int i = 3; i >= 0; i--) m_bits.push_back(d[i]);
      while (m_bits.size() > 32) void'(m_bits.pop_front());
      n = m_bits.size();
      for (int j = 0; j < 8; j++) cand[7-j] = m_bits[n - 8 - m_off + j];
      strobe = (m_cyc % 2) == 1;
      m_cyc++;
      m_valid = 1'b0;
      if (strobe) begin
         act    = !m_skip;
         m_skip = 1'b0;
         if (act && m_mode != MD_IDLE && m_mode != MD_FAIL) begin
            m_valid = 1'b1;
            m_word  = cand;
         end
         if (act && !st) begin
            if (m_mode == MD_SEARCH || m_mode == MD_VERIFY) begin
               if (cand == PAT) begin
                  m_hits = (m_mode == MD_SEARCH) ? 1 : m_hits + 1;
                  m_mode = (m_hits >= LOCKN) ? MD_LOCKED : MD_VERIFY;
               end else begin
                  m_off   = (m_off + 1) % 8;
                  m_tries = m_tries + 1;
                  m_hits  = 0;
                  m_skip  = 1'b1;
                  m_mode  = (m_tries >= 8) ? MD_FAIL : MD_SEARCH;
               end
            end else if (m_mode == MD_LOCKED && ck && cand != PAT && m_errs < 65535) begin
               m_errs++;
            end
         end
      end
      if (st) begin
         m_mode = MD_SEARCH; m_tries = 0; m_hits = 0; m_errs = 0;
      end
   endtask

   // One clock: drive inputs, clock the DUT and the model, compare all outputs.
   task automatic tick(input bit st, input bit ck, input logic [3:0] xm);
      logic [3:0] d;
      for (int i = 0; i < 4; i++) begin
         case (src_mode)
            0:       d[3-i] = pat_reg[7 - ((src_idx + src_shift) % 8)];
            1:       d[3-i] = 1'b0;
            default: d[3-i] = 1'($urandom_range(0, 1));
         endcase
         src_idx++;
      end
      d       = d ^ xm;
      data_i  = d;
      start_i = st;
      check_i = ck;
      @(posedge clk);
      mdl_step(d, st, ck);
      #1;
      check_val("valid",  32'(word_valid_o), 32'(m_valid));
      check_val("word",   32'(word_o),       32'(m_word));
      check_val("offset", 32'(offset_o),     32'(m_off));
      check_val("locked", 32'(locked_o),     32'(m_mode == MD_LOCKED));
      check_val("fail",   32'(fail_o),       32'(m_mode == MD_FAIL));
      check_val("errcnt", 32'(err_cnt_o),    32'(m_errs));
   endtask

   // Called at posedge+1; leaves the DUT out of reset at posedge+1.
   task automatic do_reset();
      rst_n   = 1'b0;
      start_i = 1'b0;
      check_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_i = 4'($urandom_range(0, 15));
         #1;
         check_val("rst_valid",  32'(word_valid_o), 32'd0);
         check_val("rst_word",   32'(word_o),       32'd0);
         check_val("rst_offset", 32'(offset_o),     32'd0);
         check_val("rst_locked", 32'(locked_o),     32'd0);
         check_val("rst_fail",   32'(fail_o),       32'd0);
         check_val("rst_errcnt", 32'(err_cnt_o),    32'd0);
         @(posedge clk);
         #1;
      end
      mdl_reset();
      src_idx = 0;
      rst_n   = 1'b1;
   endtask

   task automatic corrupt_word();
      if (m_cyc % 2 == 1) tick(1'b0, 1'b1, 4'h0);
      tick(1'b0, 1'b1, 4'hF);
      tick(1'b0, 1'b1, 4'h0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 4'h0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int  last_off;
      int  steps;
      int  exp_off;
      bit  found;
      bit  st, ck;
      logic [3:0] xm;

      pat_reg = PAT;
      rst_n = 1'b0; data_i = 4'h0; start_i = 1'b0; check_i = 1'b0;
      src_idx = 0; src_shift = 0; src_mode = 0;
      mdl_reset();
      @(posedge clk);
      #1;

      // reset with toggling data
      do_reset();

      // training byte at bit offset 3: walk 0,1,2,3 then lock
      src_mode = 0; src_shift = 3;
      tick(1'b1, 1'b0, 4'h0);
      last_off = 0; steps = 1;
      for (int i = 0; i < 60; i++) begin
         tick(1'b0, 1'b0, 4'h0);
         if (32'(offset_o) != 32'(last_off)) begin
            steps++;
            last_off = int'(offset_o);
         end
      end
      check_val("s2_steps",  32'(steps),    32'd4);
      check_val("s2_locked", 32'(locked_o), 32'd1);
      check_val("s2_offset", 32'(offset_o), 32'd3);
      check_val("s2_word",   32'(word_o),   32'(PAT));

      // constant zeros: eight slips then FAIL back at offset 0
      do_reset();
      src_mode = 1;
      tick(1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 50; i++) tick(1'b0, 1'b0, 4'h0);
      check_val("s3_fail",   32'(fail_o),   32'd1);
      check_val("s3_offset", 32'(offset_o), 32'd0);
      check_val("s3_locked", 32'(locked_o), 32'd0);
      tick(1'b1, 1'b0, 4'h0);
      check_val("s3_clear",  32'(fail_o),   32'd0);

      // corrupted word during VERIFY with five matches
      do_reset();
      src_mode = 0; src_shift = 3;
      tick(1'b1, 1'b0, 4'h0);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick(1'b0, 1'b0, 4'h0);
         found = (m_mode == MD_VERIFY && m_hits == 5);
      end
      check_val("s4_reach5", 32'(found), 32'd1);
      tick(1'b0, 1'b0, 4'hF);
      tick(1'b0, 1'b0, 4'hF);
      check_val("s4_offset", 32'(offset_o), 32'd4);
      check_val("s4_locked", 32'(locked_o), 32'd0);
      tick(1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 80; i++) tick(1'b0, 1'b0, 4'h0);
      check_val("s4_relock",  32'(locked_o), 32'd1);
      check_val("s4_reoff",   32'(offset_o), 32'd3);

      // error counting while locked
      for (int k = 0; k < 3; k++) corrupt_word();
      check_val("s5_errcnt", 32'(err_cnt_o), 32'd3);
      check_val("s5_locked", 32'(locked_o),  32'd1);
      tick(1'b1, 1'b1, 4'h0);
      check_val("s5_clear",  32'(err_cnt_o), 32'd0);

      // reset mid-VERIFY, then start on a strobe that would otherwise slip
      do_reset();
      src_mode = 0; src_shift = 0;
      tick(1'b1, 1'b0, 4'h0);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick(1'b0, 1'b0, 4'h0);
         found = (m_mode == MD_VERIFY && m_hits >= 3);
      end
      check_val("s6_reachv", 32'(found), 32'd1);
      do_reset();
      src_mode = 1;
      tick(1'b1, 1'b0, 4'h0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         found = (m_cyc % 2 == 1) && !m_skip && m_mode == MD_SEARCH;
         if (!found) tick(1'b0, 1'b0, 4'h0);
      end
      check_val("s6_align", 32'(found), 32'd1);
      exp_off = m_off;
      tick(1'b1, 1'b0, 4'h0);
      check_val("s6_noslip", 32'(offset_o), 32'(exp_off));
      tick(1'b0, 1'b0, 4'h0);
      tick(1'b0, 1'b0, 4'h0);
      check_val("s6_slip", 32'(offset_o), 32'((exp_off + 1) % 8));

      // randomized streams, starts, check levels, corruption and resets
      for (int c = 0; c < 1500; c++) begin
         if (c % 64 == 0) begin
            src_mode  = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 2));
            src_shift = int'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 599) == 0) do_reset();
         st = ($urandom_range(0, 39) == 0);
         ck = 1'($urandom_range(0, 1));
         xm = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         tick(st, ck, xm);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
